// File: rtl/cdc_pkg.sv
// Shared types and constants for the four-phase REQ/ACK clock-domain-crossing handshake.
package cdc_pkg;

   typedef enum logic [1:0] {
      IDLE       = 2'd0,
      WAIT_ACK_H = 2'd1,
      WAIT_ACK_L = 2'd2
   } cdc_hs_state_t;

   localparam int unsigned MIN_SYNC_STAGES = 2;

   // Width of a counter able to hold 0..cycles without wrapping.
   function automatic int unsigned cdc_cnt_width(input int unsigned cycles);
      return $clog2(cycles) + 1;
   endfunction

endpackage

// File: rtl/cdc_ack_sync.sv
// Single-bit multi-flop synchronizer that brings the asynchronous ACK into the CLK domain.
module cdc_ack_sync
   import cdc_pkg::*;
#(
   parameter int unsigned NUM_STAGES = MIN_SYNC_STAGES
) (
   input  logic CLK,
   input  logic RST,
   input  logic async_i,
   output logic sync_o
);

   if (NUM_STAGES < MIN_SYNC_STAGES) begin : g_stage_check
      $error("cdc_ack_sync: NUM_STAGES must be at least %0d", MIN_SYNC_STAGES);
   end

   logic [NUM_STAGES-1:0] sync_q;
   logic [NUM_STAGES-1:0] sync_d;

   always_comb begin
      sync_d = {sync_q[NUM_STAGES-2:0], async_i};
   end

   always_ff @(posedge CLK or negedge RST) begin
      if (!RST) begin
         sync_q <= '0;
      end else begin
         sync_q <= sync_d;
      end
   end

   assign sync_o = sync_q[NUM_STAGES-1];

endmodule

// File: rtl/cdc_handshake_tx.sv
// Source-domain transmitter of a four-phase REQ/ACK CDC handshake.
// Optional per-phase ACK timeout with sticky ERR is enabled by defining ACK_TIMEOUT_EN.
module cdc_handshake_tx
   import cdc_pkg::*;
#(
   parameter int unsigned BUS_WIDTH      = 8,
   parameter int unsigned NUM_STAGES     = 2,
   parameter int unsigned TIMEOUT_CYCLES = 1024
) (
   input  logic                 CLK,
   input  logic                 RST,
   input  logic [BUS_WIDTH-1:0] SRC_DATA,
   input  logic                 SRC_VALID,
   output logic                 SRC_READY,
   output logic                 DONE,
   output logic [BUS_WIDTH-1:0] TX_DATA,
   output logic                 REQ,
`ifdef ACK_TIMEOUT_EN
   output logic                 ERR,
`endif
   input  logic                 ACK
);

   if (TIMEOUT_CYCLES < 2) begin : g_timeout_check
      $error("cdc_handshake_tx: TIMEOUT_CYCLES must be at least 2");
   end

   logic ack_s;

   cdc_ack_sync #(
      .NUM_STAGES(NUM_STAGES)
   ) u_ack_sync (
      .CLK    (CLK),
      .RST    (RST),
      .async_i(ACK),
      .sync_o (ack_s)
   );

   cdc_hs_state_t        state_q, state_d;
   logic                 req_q, req_d;
   logic                 ready_q, ready_d;
   logic                 done_q, done_d;
   logic [BUS_WIDTH-1:0] tx_data_q, tx_data_d;
   // Set once ack_s has been seen low in WAIT_ACK_H, so a stray high ACK left over
   // from IDLE cannot complete the new transfer.
   logic                 armed_q, armed_d;

`ifdef ACK_TIMEOUT_EN
   localparam int unsigned CntW = cdc_cnt_width(TIMEOUT_CYCLES);
   localparam logic [CntW-1:0] CntLast = CntW'(TIMEOUT_CYCLES - 1);

   logic [CntW-1:0] cnt_q, cnt_d;
   logic            err_q, err_d;
   logic            timeout;

   assign timeout = (cnt_q == CntLast);
`endif

   always_comb begin
      state_d   = state_q;
      req_d     = req_q;
      ready_d   = ready_q;
      done_d    = 1'b0;
      tx_data_d = tx_data_q;
      armed_d   = armed_q;
`ifdef ACK_TIMEOUT_EN
      err_d     = err_q;
`endif

      unique case (state_q)
         IDLE: begin
            if (SRC_VALID) begin
               tx_data_d = SRC_DATA;
               req_d     = 1'b1;
               ready_d   = 1'b0;
               armed_d   = ~ack_s;
               state_d   = WAIT_ACK_H;
`ifdef ACK_TIMEOUT_EN
               err_d     = 1'b0;
`endif
            end
         end
         WAIT_ACK_H: begin
            if (ack_s && armed_q) begin
               req_d   = 1'b0;
               state_d = WAIT_ACK_L;
            end else begin
               if (!ack_s) begin
                  armed_d = 1'b1;
               end
`ifdef ACK_TIMEOUT_EN
               if (timeout) begin
                  err_d   = 1'b1;
                  req_d   = 1'b0;
                  state_d = WAIT_ACK_L;
               end
`endif
            end
         end
         WAIT_ACK_L: begin
            if (!ack_s) begin
`ifdef ACK_TIMEOUT_EN
               // A phase that already timed out is not a completed transfer.
               done_d  = ~err_q;
`else
               done_d  = 1'b1;
`endif
               ready_d = 1'b1;
               state_d = IDLE;
            end
`ifdef ACK_TIMEOUT_EN
            else if (timeout) begin
               err_d   = 1'b1;
               ready_d = 1'b1;
               state_d = IDLE;
            end
`endif
         end
         default: begin
            req_d   = 1'b0;
            ready_d = 1'b1;
            state_d = IDLE;
         end
      endcase

`ifdef ACK_TIMEOUT_EN
      if (state_d != state_q) begin
         cnt_d = '0;
      end else if (state_q != IDLE) begin
         cnt_d = cnt_q + 1'b1;
      end else begin
         cnt_d = cnt_q;
      end
`endif
   end

   always_ff @(posedge CLK or negedge RST) begin
      if (!RST) begin
         state_q   <= IDLE;
         req_q     <= 1'b0;
         ready_q   <= 1'b1;
         done_q    <= 1'b0;
         tx_data_q <= '0;
         armed_q   <= 1'b0;
`ifdef ACK_TIMEOUT_EN
         cnt_q     <= '0;
         err_q     <= 1'b0;
`endif
      end else begin
         state_q   <= state_d;
         req_q     <= req_d;
         ready_q   <= ready_d;
         done_q    <= done_d;
         tx_data_q <= tx_data_d;
         armed_q   <= armed_d;
`ifdef ACK_TIMEOUT_EN
         cnt_q     <= cnt_d;
         err_q     <= err_d;
`endif
      end
   end

   assign REQ       = req_q;
   assign SRC_READY = ready_q;
   assign DONE      = done_q;
   assign TX_DATA   = tx_data_q;
`ifdef ACK_TIMEOUT_EN
   assign ERR       = err_q;
`endif

endmodule

// File: tb/tb_cdc_handshake_tx.sv
// Directed, table-driven bench for cdc_handshake_tx (NUM_STAGES=2, TIMEOUT_CYCLES=16).
module tb_cdc_handshake_tx;

   logic       CLK = 1'b0;
   logic       RST;
   logic [7:0] SRC_DATA;
   logic       SRC_VALID;
   logic       SRC_READY;
   logic       DONE;
   logic [7:0] TX_DATA;
   logic       REQ;
   logic       ACK;
`ifdef ACK_TIMEOUT_EN
   logic       ERR;
`endif

   int checks = 0;
   int errors = 0;

   always #5 CLK = ~CLK;

   cdc_handshake_tx #(
      .BUS_WIDTH     (8),
      .NUM_STAGES    (2),
      .TIMEOUT_CYCLES(16)
   ) dut (
      .CLK      (CLK),
      .RST      (RST),
      .SRC_DATA (SRC_DATA),
      .SRC_VALID(SRC_VALID),
      .SRC_READY(SRC_READY),
      .DONE     (DONE),
      .TX_DATA  (TX_DATA),
      .REQ      (REQ),
`ifdef ACK_TIMEOUT_EN
      .ERR      (ERR),
`endif
      .ACK      (ACK)
   );

   typedef struct {
      logic       v;
      logic [7:0] d;
      logic       a;
      logic       req;
      logic       rdy;
      logic       done;
      logic [7:0] tx;
   } vec_t;

   vec_t vecs[$];

   function automatic void add(input logic v, input logic [7:0] d, input logic a,
                               input logic req, input logic rdy, input logic done,
                               input logic [7:0] tx);
      vec_t t;
      t.v = v; t.d = d; t.a = a; t.req = req; t.rdy = rdy; t.done = done; t.tx = tx;
      vecs.push_back(t);
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic drive(input logic v, input logic [7:0] d, input logic a);
      SRC_VALID = v;
      SRC_DATA  = d;
      ACK       = a;
   endtask

   task automatic step();
      @(posedge CLK);
      #1;
   endtask

   // Completes an already-accepted transfer with a well-behaved responder.
   task automatic finish_hs(input string tag);
      drive(1'b0, 8'h00, 1'b1);
      step(); step();
      chk({tag, "_req_hold"}, REQ, 1);
      step();
      chk({tag, "_req_fall"}, REQ, 0);
      drive(1'b0, 8'h00, 1'b0);
      step(); step();
      chk({tag, "_no_early_done"}, DONE, 0);
      step();
      chk({tag, "_done"}, DONE, 1);
      chk({tag, "_ready"}, SRC_READY, 1);
      step();
      chk({tag, "_done_clear"}, DONE, 0);
   endtask

   initial begin
      // Single transfer: ACK rises 3 cycles after REQ
      add(1, 8'hA5, 0, 1, 0, 0, 8'hA5);
      add(0, 8'h00, 0, 1, 0, 0, 8'hA5);
      add(0, 8'h00, 0, 1, 0, 0, 8'hA5);
      add(0, 8'h00, 1, 1, 0, 0, 8'hA5);
      add(0, 8'h00, 1, 1, 0, 0, 8'hA5);
      add(0, 8'h00, 1, 0, 0, 0, 8'hA5);
      add(0, 8'h00, 0, 0, 0, 0, 8'hA5);
      add(0, 8'h00, 0, 0, 0, 0, 8'hA5);
      add(0, 8'h00, 0, 0, 1, 1, 8'hA5);
      add(0, 8'h00, 0, 0, 1, 0, 8'hA5);
      // Back-to-back with SRC_VALID held
      add(1, 8'h01, 0, 1, 0, 0, 8'h01);
      add(1, 8'h01, 1, 1, 0, 0, 8'h01);
      add(1, 8'h02, 1, 1, 0, 0, 8'h01);
      add(1, 8'h02, 1, 0, 0, 0, 8'h01);
      add(1, 8'h02, 0, 0, 0, 0, 8'h01);
      add(1, 8'h02, 0, 0, 0, 0, 8'h01);
      add(1, 8'h02, 0, 0, 1, 1, 8'h01);
      add(1, 8'h02, 0, 1, 0, 0, 8'h02);
      add(0, 8'h00, 1, 1, 0, 0, 8'h02);
      add(0, 8'h00, 1, 1, 0, 0, 8'h02);
      add(0, 8'h00, 1, 0, 0, 0, 8'h02);
      add(0, 8'h00, 0, 0, 0, 0, 8'h02);
      add(0, 8'h00, 0, 0, 0, 0, 8'h02);
      add(0, 8'h00, 0, 0, 1, 1, 8'h02);
      add(0, 8'h00, 0, 0, 1, 0, 8'h02);
      // Ignored input while busy
      add(1, 8'hC3, 0, 1, 0, 0, 8'hC3);
      add(1, 8'h3C, 0, 1, 0, 0, 8'hC3);
      add(1, 8'h55, 0, 1, 0, 0, 8'hC3);
      add(1, 8'hAA, 1, 1, 0, 0, 8'hC3);
      add(0, 8'h00, 1, 1, 0, 0, 8'hC3);
      add(0, 8'h00, 1, 0, 0, 0, 8'hC3);
      add(1, 8'hFF, 0, 0, 0, 0, 8'hC3);
      add(0, 8'h00, 0, 0, 0, 0, 8'hC3);
      add(0, 8'h00, 0, 0, 1, 1, 8'hC3);
      add(0, 8'h00, 0, 0, 1, 0, 8'hC3);
      // Stray ACK in IDLE, then acceptance must wait for a fresh ACK cycle
      add(0, 8'h00, 1, 0, 1, 0, 8'hC3);
      add(0, 8'h00, 1, 0, 1, 0, 8'hC3);
      add(0, 8'h00, 1, 0, 1, 0, 8'hC3);
      add(1, 8'h7E, 1, 1, 0, 0, 8'h7E);
      add(0, 8'h00, 1, 1, 0, 0, 8'h7E);
      add(0, 8'h00, 0, 1, 0, 0, 8'h7E);
      add(0, 8'h00, 0, 1, 0, 0, 8'h7E);
      add(0, 8'h00, 0, 1, 0, 0, 8'h7E);
      add(0, 8'h00, 1, 1, 0, 0, 8'h7E);
      add(0, 8'h00, 1, 1, 0, 0, 8'h7E);
      add(0, 8'h00, 1, 0, 0, 0, 8'h7E);
      add(0, 8'h00, 0, 0, 0, 0, 8'h7E);
      add(0, 8'h00, 0, 0, 0, 0, 8'h7E);
      add(0, 8'h00, 0, 0, 1, 1, 8'h7E);
      add(0, 8'h00, 0, 0, 1, 0, 8'h7E);

      RST = 1'b0;
      drive(1'b0, 8'h00, 1'b0);
      repeat (2) @(posedge CLK);
      #1;
      chk("rst_req", REQ, 0);
      chk("rst_tx", TX_DATA, 0);
      chk("rst_done", DONE, 0);
      chk("rst_ready", SRC_READY, 1);
`ifdef ACK_TIMEOUT_EN
      chk("rst_err", ERR, 0);
`endif
      RST = 1'b1;

      foreach (vecs[i]) begin
         drive(vecs[i].v, vecs[i].d, vecs[i].a);
         step();
         chk($sformatf("vec%0d_req", i), REQ, vecs[i].req);
         chk($sformatf("vec%0d_ready", i), SRC_READY, vecs[i].rdy);
         chk($sformatf("vec%0d_done", i), DONE, vecs[i].done);
         chk($sformatf("vec%0d_tx", i), TX_DATA, vecs[i].tx);
      end

      // Asynchronous reset in the middle of WAIT_ACK_H
      drive(1'b1, 8'h99, 1'b0);
      step();
      chk("mid_accept_req", REQ, 1);
      drive(1'b0, 8'h00, 1'b0);
      step();
      #3 RST = 1'b0;
      #1;
      chk("mid_rst_req", REQ, 0);
      chk("mid_rst_tx", TX_DATA, 0);
      chk("mid_rst_done", DONE, 0);
      chk("mid_rst_ready", SRC_READY, 1);
`ifdef ACK_TIMEOUT_EN
      chk("mid_rst_err", ERR, 0);
`endif
      step();
      RST = 1'b1;
      drive(1'b1, 8'h11, 1'b0);
      step();
      chk("post_rst_req", REQ, 1);
      chk("post_rst_tx", TX_DATA, 8'h11);
      chk("post_rst_ready", SRC_READY, 0);
      finish_hs("post_rst");

`ifdef ACK_TIMEOUT_EN
      // ACK never answers: timeout after 16 cycles in WAIT_ACK_H
      drive(1'b1, 8'h5A, 1'b0);
      step();
      chk("to_accept_req", REQ, 1);
      drive(1'b0, 8'h00, 1'b0);
      for (int i = 0; i < 15; i++) begin
         step();
         chk($sformatf("to_wait%0d_done", i), DONE, 0);
      end
      chk("to_pre_req", REQ, 1);
      chk("to_pre_err", ERR, 0);
      step();
      chk("to_req", REQ, 0);
      chk("to_err", ERR, 1);
      chk("to_ready_low", SRC_READY, 0);
      step();
      chk("to_idle_ready", SRC_READY, 1);
      chk("to_no_done", DONE, 0);
      chk("to_err_sticky", ERR, 1);
      step();
      chk("to_no_done2", DONE, 0);
      drive(1'b1, 8'h3C, 1'b0);
      step();
      chk("to_err_clear", ERR, 0);
      chk("to_next_req", REQ, 1);
      chk("to_next_tx", TX_DATA, 8'h3C);
      finish_hs("to_next");
`endif

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
